// File: rtl/loop_pkg.sv
// loop_pkg: shared types and helpers for the audio looper controller.
//   - loop_state_e : FSM state encoding driven onto loop_controller.state
//   - RATE_*       : playback rate codes
//   - rate_step    : pointer advance per serviced tick for a rate code
//   - rate_div_last: last value of the tick-divide counter before an advance
// Build option: LOOP_OVERDUB_EN widens the state encoding to 3 bits and adds
// the OVERDUB state. Without it the 2-bit encoding is unchanged.
package loop_pkg;

`ifdef LOOP_OVERDUB_EN
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        RECORD  = 3'd1,
        PLAY    = 3'd2,
        PAUSE   = 3'd3,
        OVERDUB = 3'd4
    } loop_state_e;
`else
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2,
        PAUSE  = 2'd3
    } loop_state_e;
`endif

    localparam logic [2:0] RATE_MIN    = 3'd0;
    localparam logic [2:0] RATE_NORMAL = 3'd2;
    localparam logic [2:0] RATE_MAX    = 3'd4;

    function automatic logic [2:0] rate_step(input logic [2:0] rate_code);
        logic [2:0] step;
        case (rate_code)
            3'd3:    step = 3'd2;
            3'd4:    step = 3'd4;
            default: step = 3'd1;
        endcase
        return step;
    endfunction

    // Divided rates hold the pointer for several ticks; the counter advances
    // the pointer when it reaches this value.
    function automatic logic [1:0] rate_div_last(input logic [2:0] rate_code);
        logic [1:0] last;
        case (rate_code)
            3'd0:    last = 2'd3;
            3'd1:    last = 2'd1;
            default: last = 2'd0;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/loop_addr_gen.sv
// loop_addr_gen: modular pointer stepper for loop playback (combinational).
// Ports:
//   ptr     in  ADDR_W+1  current read pointer, always < len
//   step    in  3         frames to move (1, 2 or 4)
//   len     in  ADDR_W+1  loop length in frames, at least the largest step
//   reverse in  1         1 = move backwards
//   next    out ADDR_W+1  pointer after the step, wrapped into [0, len)
module loop_addr_gen
    import loop_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W:0] ptr,
    input  logic [2:0]      step,
    input  logic [ADDR_W:0] len,
    input  logic            reverse,
    output logic [ADDR_W:0] next
);

    logic [ADDR_W:0] step_ext;
    logic [ADDR_W:0] fwd;

    always_comb begin
        step_ext = (ADDR_W+1)'(step);
        fwd      = ptr + step_ext;
        next     = fwd;
        if (reverse) begin
            // ptr < len <= 2^ADDR_W, so ptr + len never exceeds ADDR_W+1 bits.
            if (ptr < step_ext) begin
                next = ptr + len - step_ext;
            end else begin
                next = ptr - step_ext;
            end
        end else if (fwd >= len) begin
            next = fwd - len;
        end
    end

endmodule

// File: rtl/loop_controller.sv
// loop_controller: record/play/pause sequencer for the audio looper.
// Turns button pulses and the per-frame codec strobe into sample-memory
// address and read/write strobes shared by both looper channels, and keeps
// playback rate, direction and loop length.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   clear                 abandon loop, back to IDLE (beats every other input)
//   btn                   advances the FSM
//   sample_tick           one pulse per codec frame
//   speed_up, slow_down   rate code +1 / -1 (saturating)
//   reverse               level, 1 = play backwards
//   overdub               toggles PLAY/OVERDUB (LOOP_OVERDUB_EN only)
//   mem_addr, mem_we, mem_re  sample memory access, one-cycle strobes
//   state, loop_len, rate, overflow  status, all registered
// Build option: LOOP_OVERDUB_EN adds the overdub input and OVERDUB state.
//
// state   | meaning
// IDLE    | no loop; waiting for btn to start recording
// RECORD  | writing one frame per tick at wr_ptr
// PLAY    | reading one frame per tick at rd_ptr, advancing by rate
// PAUSE   | no strobes, rd_ptr held
// OVERDUB | read then write back at rd_ptr each tick, rate forced normal
module loop_controller
    import loop_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int MIN_LEN = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               btn,
    input  logic               sample_tick,
    input  logic               speed_up,
    input  logic               slow_down,
    input  logic               reverse,
`ifdef LOOP_OVERDUB_EN
    input  logic               overdub,
`endif
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic               mem_re,
    output logic [STATE_W-1:0] state,
    output logic [ADDR_W:0]    loop_len,
    output logic [2:0]         rate,
    output logic               overflow
);

    localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] MEM_DEPTH = ONE << ADDR_W;
    localparam logic [ADDR_W:0] LAST_ADDR = MEM_DEPTH - ONE;
    localparam logic [ADDR_W:0] MIN_LEN_V = (ADDR_W+1)'(MIN_LEN);

    loop_state_e     st;
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] rd_ptr_nxt;
    logic [ADDR_W:0] rec_len;
    logic [2:0]      rate_q;
    logic [2:0]      rate_nxt;
    logic            rate_chg;
    logic [1:0]      div_cnt;
    logic            advance;
    logic            play_tick;
    logic [2:0]      adv_step;
`ifdef LOOP_OVERDUB_EN
    logic            pending_wr;
`endif

    assign state = st;

    always_comb begin
        rate_nxt = rate_q;
        if (speed_up && !slow_down && rate_q != RATE_MAX) begin
            rate_nxt = rate_q + 3'd1;
        end else if (slow_down && !speed_up && rate_q != RATE_MIN) begin
            rate_nxt = rate_q - 3'd1;
        end
    end

    assign rate_chg  = (rate_nxt != rate_q);
    assign play_tick = (st == PLAY) && sample_tick;
    assign advance   = (div_cnt == rate_div_last(rate_q));
    // A take's length includes a frame written in the same cycle as btn.
    assign rec_len   = wr_ptr + (ADDR_W+1)'(sample_tick);

`ifdef LOOP_OVERDUB_EN
    // The overdub write-back always moves one frame, whatever the stored rate.
    assign adv_step = pending_wr ? 3'd1 : rate_step(rate_q);
`else
    assign adv_step = rate_step(rate_q);
`endif

    loop_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .ptr     (rd_ptr),
        .step    (adv_step),
        .len     (loop_len),
        .reverse (reverse),
        .next    (rd_ptr_nxt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st         <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            loop_len   <= '0;
            rate_q     <= RATE_NORMAL;
            rate       <= RATE_NORMAL;
            div_cnt    <= '0;
            overflow   <= 1'b0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_addr   <= '0;
`ifdef LOOP_OVERDUB_EN
            pending_wr <= 1'b0;
`endif
        end else if (clear) begin
            st         <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            loop_len   <= '0;
            rate_q     <= RATE_NORMAL;
            rate       <= RATE_NORMAL;
            div_cnt    <= '0;
            overflow   <= 1'b0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_addr   <= '0;
`ifdef LOOP_OVERDUB_EN
            pending_wr <= 1'b0;
`endif
        end else begin
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            rate_q <= rate_nxt;
`ifdef LOOP_OVERDUB_EN
            rate   <= (st == OVERDUB) ? RATE_NORMAL : rate_nxt;
`else
            rate   <= rate_nxt;
`endif

            // The advance decision uses the rate in force at this tick; a
            // simultaneous rate change still restarts the divide count.
            if (rate_chg) begin
                div_cnt <= '0;
            end else if (play_tick) begin
                div_cnt <= advance ? 2'd0 : div_cnt + 2'd1;
            end

            case (st)
                IDLE: begin
                    if (btn) begin
                        st     <= RECORD;
                        wr_ptr <= '0;
                    end
                end

                RECORD: begin
                    if (sample_tick) begin
                        mem_we   <= 1'b1;
                        mem_addr <= wr_ptr[ADDR_W-1:0];
                        wr_ptr   <= wr_ptr + ONE;
                    end
                    if (sample_tick && wr_ptr == LAST_ADDR) begin
                        st       <= PLAY;
                        loop_len <= MEM_DEPTH;
                        overflow <= 1'b1;
                        rd_ptr   <= reverse ? LAST_ADDR : '0;
                    end else if (btn) begin
                        if (rec_len >= MIN_LEN_V) begin
                            st       <= PLAY;
                            loop_len <= rec_len;
                            rd_ptr   <= reverse ? rec_len - ONE : '0;
                        end else begin
                            st       <= IDLE;
                            loop_len <= '0;
                        end
                    end
                end

                PLAY: begin
                    if (sample_tick) begin
                        mem_re   <= 1'b1;
                        mem_addr <= rd_ptr[ADDR_W-1:0];
                        if (advance) begin
                            rd_ptr <= rd_ptr_nxt;
                        end
                    end
                    if (btn) begin
                        st <= PAUSE;
                    end
`ifdef LOOP_OVERDUB_EN
                    else if (overdub) begin
                        st   <= OVERDUB;
                        rate <= RATE_NORMAL;
                    end
`endif
                end

                PAUSE: begin
                    if (btn) begin
                        st <= PLAY;
                    end
                end

`ifdef LOOP_OVERDUB_EN
                OVERDUB: begin
                    if (sample_tick) begin
                        mem_re     <= 1'b1;
                        mem_addr   <= rd_ptr[ADDR_W-1:0];
                        pending_wr <= 1'b1;
                    end
                    if (btn) begin
                        st   <= PAUSE;
                        rate <= rate_nxt;
                    end else if (overdub) begin
                        st   <= PLAY;
                        rate <= rate_nxt;
                    end
                end
`endif

                default: st <= IDLE;
            endcase

`ifdef LOOP_OVERDUB_EN
            // Write-back one cycle after the overdub read, to the address
            // still held on mem_addr; it completes even if the state changed.
            if (pending_wr) begin
                mem_we     <= 1'b1;
                pending_wr <= 1'b0;
                rd_ptr     <= rd_ptr_nxt;
            end
`endif
        end
    end

endmodule

// File: tb/tb_loop_controller.sv
module tb_loop_controller;
    import loop_pkg::*;

    localparam int ADDR_W  = 4;
    localparam int MIN_LEN = 4;
    localparam int DEPTH   = 1 << ADDR_W;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               clear = 1'b0;
    logic               btn = 1'b0;
    logic               sample_tick = 1'b0;
    logic               speed_up = 1'b0;
    logic               slow_down = 1'b0;
    logic               reverse = 1'b0;
`ifdef LOOP_OVERDUB_EN
    logic               overdub = 1'b0;
`endif
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_we;
    logic               mem_re;
    logic [STATE_W-1:0] state;
    logic [ADDR_W:0]    loop_len;
    logic [2:0]         rate;
    logic               overflow;

    loop_controller #(.ADDR_W(ADDR_W), .MIN_LEN(MIN_LEN)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .btn         (btn),
        .sample_tick (sample_tick),
        .speed_up    (speed_up),
        .slow_down   (slow_down),
        .reverse     (reverse),
`ifdef LOOP_OVERDUB_EN
        .overdub     (overdub),
`endif
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .state       (state),
        .loop_len    (loop_len),
        .rate        (rate),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit run_chk = 1'b0;
    int rd_log[$];
    int wr_log[$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_log(input string name, input int got[$], input int exp[$]);
        check({name, ".count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s[%0d]", name, i), got[i], exp[i]);
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the looper as "what frame is being recorded / played" using
    // plain integer arithmetic and modulo wrap.
    int m_st, m_wr, m_rd, m_len, m_rate, m_ticks, m_ovf, m_we, m_re, m_addr;

    function automatic int period_of(input int r);
        return (r == 0) ? 4 : (r == 1) ? 2 : 1;
    endfunction

    function automatic int step_of(input int r);
        return (r == 3) ? 2 : (r == 4) ? 4 : 1;
    endfunction

    task automatic model_reset();
        m_st = 0; m_wr = 0; m_rd = 0; m_len = 0; m_rate = 2; m_ticks = 0;
        m_ovf = 0; m_we = 0; m_re = 0; m_addr = 0;
    endtask

    always @(posedge clk or negedge reset_n) begin
        int new_rate;
        int taken;
        int stp;
        if (!reset_n || clear) begin
            model_reset();
        end else begin
            m_we = 0;
            m_re = 0;
            new_rate = m_rate;
            if (speed_up && !slow_down && m_rate < 4) new_rate = m_rate + 1;
            if (slow_down && !speed_up && m_rate > 0) new_rate = m_rate - 1;
            case (m_st)
                0: if (btn) begin m_st = 1; m_wr = 0; end
                1: begin
                    taken = m_wr + (sample_tick ? 1 : 0);
                    if (sample_tick) begin
                        m_we = 1; m_addr = m_wr; m_wr = m_wr + 1;
                    end
                    if (taken == DEPTH) begin
                        m_st = 2; m_len = DEPTH; m_ovf = 1;
                        m_rd = reverse ? DEPTH - 1 : 0;
                    end else if (btn) begin
                        if (taken >= MIN_LEN) begin
                            m_st = 2; m_len = taken;
                            m_rd = reverse ? taken - 1 : 0;
                        end else begin
                            m_st = 0; m_len = 0;
                        end
                    end
                end
                2: begin
                    if (sample_tick) begin
                        m_re = 1; m_addr = m_rd;
                        m_ticks++;
                        if (m_ticks == period_of(m_rate)) begin
                            m_ticks = 0;
                            stp = step_of(m_rate);
                            if (reverse) m_rd = (m_rd - stp + m_len) % m_len;
                            else         m_rd = (m_rd + stp) % m_len;
                        end
                    end
                    if (btn) m_st = 3;
                end
                default: if (btn) m_st = 2;
            endcase
            if (new_rate != m_rate) m_ticks = 0;
            m_rate = new_rate;
        end
    end

    always @(negedge clk) begin
        if (mem_we) wr_log.push_back(int'(mem_addr));
        if (mem_re) rd_log.push_back(int'(mem_addr));
        if (run_chk) begin
            check("state",    int'(state),    m_st);
            check("loop_len", int'(loop_len), m_len);
            check("rate",     int'(rate),     m_rate);
            check("overflow", int'(overflow), m_ovf);
            check("mem_we",   int'(mem_we),   m_we);
            check("mem_re",   int'(mem_re),   m_re);
            check("mem_addr", int'(mem_addr), m_addr);
        end
    end

    // ---------------- stimulus helpers (drive at negedge + 1) ----------------
    task automatic step1();
        @(negedge clk);
        #1;
    endtask

    task automatic tick();
        sample_tick = 1'b1; step1();
        sample_tick = 1'b0; step1();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press();
        btn = 1'b1; step1(); btn = 1'b0; step1();
    endtask

    task automatic pulse_speed(input bit up, input bit down);
        speed_up = up; slow_down = down; step1();
        speed_up = 1'b0; slow_down = 1'b0; step1();
    endtask

    task automatic do_clear();
        clear = 1'b1; step1(); clear = 1'b0; step1();
    endtask

    int exp_q[$];
    int since_tick;

    initial begin
        reset_n = 1'b0;
        repeat (3) step1();
        run_chk = 1'b1;
        check("rst.state", int'(state), 0);
        check("rst.rate", int'(rate), 2);
        check("rst.mem_addr", int'(mem_addr), 0);
        reset_n = 1'b1;
        step1();

        // record 10 frames, play 12 ticks
        press();
        wr_log.delete();
        ticks(10);
        press();
        exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        check_log("rec10.wr", wr_log, exp_q);
        check("rec10.state", int'(state), 2);
        check("rec10.loop_len", int'(loop_len), 10);
        rd_log.delete();
        ticks(12);
        exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
        check_log("play12.rd", rd_log, exp_q);

        // reverse at rate 4 from rd_ptr 1
        reverse = 1'b1;
        tick();
        pulse_speed(1'b1, 1'b0);
        pulse_speed(1'b1, 1'b0);
        pulse_speed(1'b1, 1'b0);
        check("rate.sat_hi", int'(rate), 4);
        rd_log.delete();
        ticks(4);
        exp_q = '{1, 7, 3, 9};
        check_log("rev4.rd", rd_log, exp_q);
        reverse = 1'b0;

        // rate 0 on an 8-frame loop
        do_clear();
        press();
        ticks(8);
        press();
        pulse_speed(1'b0, 1'b1);
        pulse_speed(1'b0, 1'b1);
        pulse_speed(1'b0, 1'b1);
        check("rate.sat_lo", int'(rate), 0);
        rd_log.delete();
        ticks(8);
        exp_q = '{0, 0, 0, 0, 1, 1, 1, 1};
        check_log("rate0.rd", rd_log, exp_q);
        pulse_speed(1'b1, 1'b1);
        check("rate.both", int'(rate), 0);
        do_clear();
        check("clear.state", int'(state), 0);
        check("clear.rate", int'(rate), 2);

        // short take is discarded
        press();
        ticks(3);
        press();
        check("short.state", int'(state), 0);
        check("short.loop_len", int'(loop_len), 0);
        rd_log.delete();
        ticks(3);
        check("short.reads", rd_log.size(), 0);

        // fill memory: automatic PLAY with overflow
        press();
        ticks(DEPTH);
        check("ovf.state", int'(state), 2);
        check("ovf.loop_len", int'(loop_len), DEPTH);
        check("ovf.flag", int'(overflow), 1);
        rd_log.delete();
        tick();
        exp_q = '{0};
        check_log("ovf.rd", rd_log, exp_q);

        // asynchronous reset while a read strobe is high
        sample_tick = 1'b1;
        @(posedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        #1;
        sample_tick = 1'b0;
        check("rstmid.mem_re", int'(mem_re), 0);
        check("rstmid.state", int'(state), 0);
        reset_n = 1'b1;
        step1();

        // randomized phase against the model
        since_tick = 2;
        for (int it = 0; it < 4000; it++) begin
            btn = 1'b0; clear = 1'b0; sample_tick = 1'b0;
            speed_up = 1'b0; slow_down = 1'b0;
            if ($urandom_range(0, 599) == 0) begin
                @(posedge clk);
                #2 reset_n = 1'b0;
                @(negedge clk);
                #1 reset_n = 1'b1;
                since_tick = 2;
                continue;
            end
            clear       = ($urandom_range(0, 399) == 0);
            btn         = ($urandom_range(0, 29) == 0);
            speed_up    = ($urandom_range(0, 19) == 0);
            slow_down   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) reverse = ~reverse;
            if (since_tick >= 2 && $urandom_range(0, 1) == 1) begin
                sample_tick = 1'b1;
                since_tick = 0;
            end
            since_tick++;
            step1();
        end
        btn = 1'b0; clear = 1'b0; sample_tick = 1'b0;
        speed_up = 1'b0; slow_down = 1'b0;
        step1();
        run_chk = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
